// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue slice.
//   alu_ctrl_e : 4-bit ALU control codes understood by alu
//   alu_op_e   : 2-bit ALUOp from the main decoder
//   FUNCT_*    : R-type funct values that map onto ALU operations
package alu_pkg;

  typedef enum logic [3:0] {
    CTRL_AND = 4'b0000,
    CTRL_OR  = 4'b0001,
    CTRL_ADD = 4'b0010,
    CTRL_SUB = 4'b0110,
    CTRL_SLT = 4'b0111,
    CTRL_NOR = 4'b1100
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD     = 2'b00,
    ALUOP_SUB     = 2'b01,
    ALUOP_FUNCT   = 2'b10,
    ALUOP_ILLEGAL = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu.sv
// alu: 32-bit combinational ALU.
//   ctrl in 4 : operation code (0000 and, 0001 or, 0010 add, 0110 sub,
//               0111 slt signed, 1100 nor)
//   a, b in 32: operands
//   out out 32: result, modulo 2^32; unknown codes yield 0
module alu (
  input  logic [3:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    out = '0;
    case (ctrl)
      4'b0000: out = a & b;
      4'b0001: out = a | b;
      4'b0010: out = a + b;
      4'b0110: out = a - b;
      4'b0111: out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: out = ~(a | b);
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALUOp/funct to ALU control decode.
//   alu_op  in 2 : 00 add, 01 sub, 10 use funct, 11 illegal
//   funct   in 6 : R-type funct field
//   ctrl    out  : ALU control code (ADD when illegal)
//   illegal out 1: operation does not map onto an ALU function
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_ctrl_e  ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_ADD;
    illegal = 1'b0;
    case (alu_op_e'(alu_op))
      ALUOP_ADD: ctrl = CTRL_ADD;
      ALUOP_SUB: ctrl = CTRL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_OR:  ctrl = CTRL_OR;
          FUNCT_NOR: ctrl = CTRL_NOR;
          FUNCT_SLT: ctrl = CTRL_SLT;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage issue/capture wrapper around alu.
// S1 holds decoded operands and drives alu; S2 captures the result.
// Optional feature macro: ALU_ISSUE_ZERO_FLAG_EN adds the out_zero port.
//   clk, rst (sync, active-high)
//   in_valid/in_ready, in_alu_op, in_funct, in_a, in_b, in_tag : request
//   out_valid/out_ready, out_result, out_tag, out_illegal     : response
//   out_zero (macro only) : registered result == 0
//   op_count : results consumed downstream, wraps
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [5:0]       in_funct,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic [CNT_W-1:0] op_count
);

  alu_ctrl_e dec_ctrl;
  logic      dec_illegal;

  logic             s1_valid;
  logic [31:0]      s1_a, s1_b;
  alu_ctrl_e        s1_ctrl;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_illegal;

  logic             s2_valid;
  logic [31:0]      s2_result;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_illegal;

  logic [31:0] alu_out;
  logic        s1_load, s2_load;

  alu_ctrl_decode u_decode (
    .alu_op  (in_alu_op),
    .funct   (in_funct),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  alu u_alu (
    .ctrl (s1_ctrl),
    .a    (s1_a),
    .b    (s1_b),
    .out  (alu_out)
  );

  // S2 frees up in the same cycle it drains, so S1 can advance behind it
  // without a bubble; out_valid itself stays a pure register output.
  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: all registers are reset, payload included, so outputs read as zero out of reset.
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_ctrl    <= CTRL_ADD;
      s1_tag     <= '0;
      s1_illegal <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid   <= 1'b1;
        s1_a       <= in_a;
        s1_b       <= in_b;
        s1_ctrl    <= dec_ctrl;
        s1_tag     <= in_tag;
        s1_illegal <= dec_illegal;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_tag     <= '0;
      s2_illegal <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid   <= 1'b1;
        s2_result  <= s1_illegal ? 32'd0 : alu_out;
        s2_tag     <= s1_tag;
        s2_illegal <= s1_illegal;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_zero <= 1'b0;
    end else if (s2_load) begin
      out_zero <= s1_illegal || (alu_out == 32'd0);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (s2_valid && out_ready) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_tag     = s2_tag;
  assign out_illegal = s2_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage.
// Build with +define+ALU_ISSUE_ZERO_FLAG_EN to also check out_zero.
module tb_alu_issue_stage;

  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_alu_op;
  logic [5:0]       in_funct;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic             out_zero;
`endif
  logic [CNT_W-1:0] op_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alu_op   (in_alu_op),
    .in_funct    (in_funct),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_illegal (out_illegal),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    .out_zero    (out_zero),
`endif
    .op_count    (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation with out_ready=1, check it two edges later, let it drain.
  task automatic run_one(input string name, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] exp_res, input logic exp_ill);
    in_valid  = 1'b1;
    in_alu_op = op;
    in_funct  = fn;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = 1'b1;
    #1;
    check({name, "/in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check({name, "/no_early_valid"}, 32'(out_valid), 32'd0);
    step();
    check({name, "/out_valid"},   32'(out_valid),   32'd1);
    check({name, "/out_result"},  out_result,       exp_res);
    check({name, "/out_tag"},     32'(out_tag),     32'(tag));
    check({name, "/out_illegal"}, 32'(out_illegal), 32'(exp_ill));
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    check({name, "/out_zero"},    32'(out_zero),    32'(exp_res == 32'd0));
`endif
    step();
    exp_count++;
    check({name, "/op_count"},    32'(op_count),    32'(exp_count % (1 << CNT_W)));
    check({name, "/drained"},     32'(out_valid),   32'd0);
  endtask

  initial begin
    logic [3:0]       rdy_pat;
    int               sent, got;
    bit               m1, m2, s2l, in_fire, holding;
    logic [31:0]      hold_res;
    logic [TAG_W-1:0] hold_tag;
    logic             exp_in_ready;

    rst = 1'b1; in_valid = 1'b0; in_alu_op = 2'b00; in_funct = 6'd0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("reset/in_ready",    32'(in_ready),    32'd1);
    check("reset/out_valid",   32'(out_valid),   32'd0);
    check("reset/out_result",  out_result,       32'd0);
    check("reset/out_tag",     32'(out_tag),     32'd0);
    check("reset/out_illegal", 32'(out_illegal), 32'd0);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    check("reset/out_zero",    32'(out_zero),    32'd0);
`endif
    check("reset/op_count",    32'(op_count),    32'd0);
    step();

    // Stream of 8 adds (a=i, b=100, tag=i) with out_ready cycling 1,0,0,1.
    rdy_pat = 4'b1001;
    sent = 0; got = 0; m1 = 0; m2 = 0; holding = 0;
    hold_res = '0; hold_tag = '0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      in_valid  = (sent < 8);
      in_alu_op = 2'b00;
      in_funct  = 6'd0;
      in_a      = 32'(sent);
      in_b      = 32'd100;
      in_tag    = TAG_W'(sent);
      out_ready = rdy_pat[cyc % 4];
      #1;
      exp_in_ready = !(m1 && m2 && !out_ready);
      check("stream/in_ready",  32'(in_ready),  32'(exp_in_ready));
      check("stream/out_valid", 32'(out_valid), 32'(m2));
      if (holding) begin
        check("stream/hold_result", out_result,   hold_res);
        check("stream/hold_tag",    32'(out_tag), 32'(hold_tag));
      end
      in_fire = in_valid && exp_in_ready;
      if (m2 && out_ready) begin
        check("stream/result", out_result,   32'd100 + 32'(got));
        check("stream/tag",    32'(out_tag), 32'(got % 16));
        got++;
      end
      holding  = m2 && !out_ready;
      hold_res = out_result;
      hold_tag = out_tag;
      if (in_fire) sent++;
      s2l = m1 && (!m2 || out_ready);
      m2  = s2l || (m2 && !out_ready);
      m1  = in_fire || (m1 && !s2l);
      step();
    end
    in_valid = 1'b0;
    check("stream/all_received", 32'(got), 32'd8);
    check("stream/op_count",     32'(op_count), 32'd8);
    check("stream/drained",      32'(out_valid), 32'd0);
    exp_count = 8;

    run_one("add_5_6",    2'b00, 6'd0,      32'd5,  32'd6,  4'h1, 32'd11, 1'b0);
    run_one("funct_sub",  2'b10, 6'b100010, 32'd10, 32'd4,  4'h2, 32'd6,  1'b0);
    run_one("sub_zero",   2'b10, 6'b100010, 32'd7,  32'd7,  4'h3, 32'd0,  1'b0);
    run_one("op_sub_neg", 2'b01, 6'd0,      32'd3,  32'd5,  4'h4, 32'hFFFFFFFE, 1'b0);
    run_one("and",        2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 4'h5, 32'h0000F000, 1'b0);
    run_one("or",         2'b10, 6'b100101, 32'h0000F0F0, 32'h0000FF00, 4'h6, 32'h0000FFF0, 1'b0);
    run_one("nor",        2'b10, 6'b100111, 32'h0F0F0000, 32'h00000000, 4'h7, 32'hF0F0FFFF, 1'b0);
    run_one("ill_funct",  2'b10, 6'b000000, 32'd3,  32'd4,  4'h8, 32'd0,  1'b1);
    run_one("ill_op11",   2'b11, 6'b100000, 32'd9,  32'd1,  4'h9, 32'd0,  1'b1);
    run_one("slt_neg",    2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 4'hA, 32'd1, 1'b0);
    run_one("slt_pos",    2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 4'hB, 32'd0, 1'b0);
    run_one("add_wrap",   2'b00, 6'd0,      32'hFFFFFFFF, 32'd1, 4'hC, 32'd0, 1'b0);

    // Fill S1 and S2 under backpressure, then reset mid-flight.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_alu_op = 2'b00; in_a = 32'd1; in_b = 32'd1; in_tag = 4'h9;
    step();
    in_a = 32'd2; in_tag = 4'hA;
    step();
    in_valid = 1'b0;
    #1;
    check("full/in_ready",  32'(in_ready),  32'd0);
    check("full/out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst/out_valid", 32'(out_valid), 32'd0);
    check("midrst/in_ready",  32'(in_ready),  32'd1);
    check("midrst/op_count",  32'(op_count),  32'd0);
    step();
    check("midrst/next_out_valid", 32'(out_valid), 32'd0);
    check("midrst/next_op_count",  32'(op_count),  32'd0);
    exp_count = 0;
    run_one("post_rst_add", 2'b00, 6'd0, 32'd20, 32'd22, 4'hD, 32'd42, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
